// File: rtl/frame_clearer_pkg.sv
// frame_clearer_pkg
//   Shared definitions for the frame clearer and the blocks around it:
//   Avalon-MM port widths of the f2h SDRAM write port, frame buffer geometry,
//   the clearer's state encoding and a burst sizing helper.
package frame_clearer_pkg;

  // Avalon-MM f2h SDRAM write port (64-bit data, 8-byte words).
  localparam int AV_ADDR_W       = 29;
  localparam int AV_DATA_W       = 64;
  localparam int AV_BURSTCOUNT_W = 8;

  // Frame buffer geometry: 800x480 pixels, 32 bits per pixel.
  localparam logic [29:0] FRAME_BUFFER_ADDRESS = 30'h3800_0000;
  localparam int          FRAME_BUFFER_WIDTH   = 800;
  localparam int          FRAME_BUFFER_HEIGHT  = 480;
  localparam int          FRAME_BUFFER_LENGTH  = FRAME_BUFFER_WIDTH * FRAME_BUFFER_HEIGHT * 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } clear_state_t;

  // Beats in the next burst: the burst limit, or fewer when the region ends sooner.
  function automatic logic [AV_BURSTCOUNT_W-1:0] burst_size(input int unsigned max_beats,
                                                            input int unsigned remaining);
    return (remaining < max_beats) ? AV_BURSTCOUNT_W'(remaining) : AV_BURSTCOUNT_W'(max_beats);
  endfunction

endpackage

// File: rtl/frame_clearer.sv
// frame_clearer
//   Avalon-MM burst write master that fills one frame-sized region of SDRAM
//   with a constant 32-bit pixel value (two pixels per 64-bit word). Bursts are
//   issued back-to-back; the last burst may be short.
//
// Ports
//   clock          system clock (clock_50 domain)
//   reset_n        asynchronous active-low reset
//   start          one-cycle fill request, ignored while busy
//   buffer_select  0: fill buffer at ADDRESS, 1: buffer at ADDRESS+LENGTH
//   value          fill pixel, sampled with start
//   busy           fill in progress
//   done           one-cycle pulse when the last beat has been accepted
//   address        Avalon word address of the current burst
//   burstcount     beats in the current burst
//   waitrequest    slave stall
//   writedata      {value, value}
//   byteenable     all bytes enabled
//   write          beat valid
//   debug_value0   words written since the last accepted start
module frame_clearer
  import frame_clearer_pkg::*;
#(
  parameter logic [29:0] ADDRESS      = FRAME_BUFFER_ADDRESS,
  parameter int          LENGTH       = FRAME_BUFFER_LENGTH,
  parameter int          BURST_LENGTH = 8
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic                       buffer_select,
  input  logic [31:0]                value,
  output logic                       busy,
  output logic                       done,
  output logic [AV_ADDR_W-1:0]       address,
  output logic [AV_BURSTCOUNT_W-1:0] burstcount,
  input  logic                       waitrequest,
  output logic [AV_DATA_W-1:0]       writedata,
  output logic [AV_DATA_W/8-1:0]     byteenable,
  output logic                       write,
  output logic [31:0]                debug_value0
);

  localparam int NUM_WORDS = LENGTH / 8;
  localparam int WR_W      = $clog2(NUM_WORDS + 1);

  localparam logic [WR_W-1:0] WORDS_INIT = WR_W'(NUM_WORDS);
  localparam logic [WR_W-1:0] ONE_WORD   = WR_W'(1);

  // Byte addresses of the two buffers; dropping the low three bits gives the
  // Avalon word address.
  localparam logic [31:0] BYTE_BASE0 = 32'(ADDRESS);
  localparam logic [31:0] BYTE_BASE1 = 32'(ADDRESS) + 32'(LENGTH);

  localparam logic [AV_ADDR_W-1:0]       WORD_BASE0  = BYTE_BASE0[31:3];
  localparam logic [AV_ADDR_W-1:0]       WORD_BASE1  = BYTE_BASE1[31:3];
  localparam logic [AV_BURSTCOUNT_W-1:0] FIRST_BURST = burst_size(BURST_LENGTH, NUM_WORDS);

  clear_state_t                state, state_next;
  logic [WR_W-1:0]             words_remaining;
  logic [WR_W-1:0]             words_after;
  logic [AV_BURSTCOUNT_W-1:0]  beat_index;
  logic [31:0]                 value_q;
  logic                        accept;
  logic                        burst_end;
  logic                        fill_end;

  // Both flags decode registered state, so write and busy carry no
  // combinational path from waitrequest.
  assign write      = (state == ST_WRITE);
  assign busy       = (state == ST_WRITE);
  assign writedata  = {value_q, value_q};
  assign byteenable = '1;

  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves one unassigned and no latch is inferred.
  always_comb begin
    state_next  = state;
    accept      = (state == ST_WRITE) && !waitrequest;
    words_after = words_remaining - ONE_WORD;
    burst_end   = accept && (beat_index == burstcount - 8'd1);
    fill_end    = accept && (words_remaining == ONE_WORD);
    case (state)
      ST_IDLE:  if (start)    state_next = ST_WRITE;
      ST_WRITE: if (fill_end) state_next = ST_IDLE;
      default:                state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      address         <= '0;
      burstcount      <= '0;
      words_remaining <= '0;
      beat_index      <= '0;
      value_q         <= '0;
      debug_value0    <= '0;
      done            <= 1'b0;
    end else begin
      done <= fill_end;

      if (state == ST_IDLE && start) begin
        value_q         <= value;
        address         <= buffer_select ? WORD_BASE1 : WORD_BASE0;
        burstcount      <= FIRST_BURST;
        words_remaining <= WORDS_INIT;
        beat_index      <= '0;
        debug_value0    <= '0;
      end else if (accept) begin
        words_remaining <= words_after;
        debug_value0    <= debug_value0 + 32'd1;
        if (burst_end) begin
          beat_index <= '0;
          // Address and burstcount only move once the whole burst is taken;
          // after the final burst they simply hold.
          if (!fill_end) begin
            address    <= address + AV_ADDR_W'(burstcount);
            burstcount <= burst_size(BURST_LENGTH, 32'(words_after));
          end
        end else begin
          beat_index <= beat_index + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_frame_clearer.sv
// tb_frame_clearer
//   Directed bench for frame_clearer. Instance a: ADDRESS=30'h100, LENGTH=64,
//   BURST_LENGTH=4 (buffer 0 at word 29'h20, buffer 1 at 29'h28). Instance b:
//   LENGTH=48, BURST_LENGTH=4 (bursts of 4 then 2). A small word memory records
//   every accepted beat so region contents and neighbours can be checked.
module tb_frame_clearer;

  logic        clock;
  logic        reset_n;

  logic        start_a, sel_a, busy_a, done_a, waitrequest_a, write_a;
  logic [31:0] value_a, dbg_a;
  logic [28:0] address_a;
  logic [7:0]  burstcount_a, byteenable_a;
  logic [63:0] writedata_a;

  logic        start_b, sel_b, busy_b, done_b, waitrequest_b, write_b;
  logic [31:0] value_b, dbg_b;
  logic [28:0] address_b;
  logic [7:0]  burstcount_b, byteenable_b;
  logic [63:0] writedata_b;

  int checks   = 0;
  int failures = 0;

  logic [63:0] mem [0:63];
  logic [28:0] burst_addr [0:3];
  logic [7:0]  burst_bc [0:3];
  int          n_bursts;
  int          n_beats;
  int          last_cycles;

  frame_clearer #(.ADDRESS(30'h100), .LENGTH(64), .BURST_LENGTH(4)) dut_a (
    .clock(clock), .reset_n(reset_n), .start(start_a), .buffer_select(sel_a),
    .value(value_a), .busy(busy_a), .done(done_a), .address(address_a),
    .burstcount(burstcount_a), .waitrequest(waitrequest_a), .writedata(writedata_a),
    .byteenable(byteenable_a), .write(write_a), .debug_value0(dbg_a)
  );

  frame_clearer #(.ADDRESS(30'h100), .LENGTH(48), .BURST_LENGTH(4)) dut_b (
    .clock(clock), .reset_n(reset_n), .start(start_b), .buffer_select(sel_b),
    .value(value_b), .busy(busy_b), .done(done_b), .address(address_b),
    .burstcount(burstcount_b), .waitrequest(waitrequest_b), .writedata(writedata_b),
    .byteenable(byteenable_b), .write(write_b), .debug_value0(dbg_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) mem[i] = '0;
  endtask

  task automatic check_region(input int base, input logic [31:0] val);
    for (int i = 0; i < 8; i++) check("region_word", mem[base + i], {val, val});
    check("neighbour_below", mem[base - 1], 64'h0);
    check("neighbour_above", mem[base + 8], 64'h0);
  endtask

  task automatic start_a_fill(input logic sel, input logic [31:0] val);
    start_a = 1'b1;
    sel_a   = sel;
    value_a = val;
    tick();
    start_a = 1'b0;
    check("start_write", write_a, 1'b1);
    check("start_busy", busy_a, 1'b1);
    check("start_dbg_zero", dbg_a, 32'd0);
  endtask

  // Runs instance a until done, checking every write cycle against a burst
  // model. inject_cyc>0 pulses a bogus start on that cycle of the fill.
  task automatic run_a(input logic sel, input logic [31:0] val, input bit stall,
                       input int inject_cyc);
    int          cyc  = 1;
    int          rem  = 8;
    int          beat = 0;
    int          idx;
    logic [28:0] exp_addr;
    logic [7:0]  exp_bc;
    exp_addr = sel ? 29'h28 : 29'h20;
    exp_bc   = 8'd4;
    n_bursts = 0;
    n_beats  = 0;
    while (!done_a && cyc < 300) begin
      waitrequest_a = stall ? 1'($urandom_range(0, 1)) : 1'b0;
      if (cyc == inject_cyc) begin
        start_a = 1'b1;
        sel_a   = ~sel;
        value_a = ~val;
      end
      if (write_a) begin
        check("beat_address", address_a, exp_addr);
        check("beat_burstcount", burstcount_a, exp_bc);
        check("beat_writedata", writedata_a, {val, val});
        check("beat_byteenable", byteenable_a, 8'hFF);
        if (!waitrequest_a) begin
          if (beat == 0 && n_bursts < 4) begin
            burst_addr[n_bursts] = address_a;
            burst_bc[n_bursts]   = burstcount_a;
            n_bursts++;
          end
          idx = int'(address_a) + beat;
          if (idx < 64) mem[idx] = writedata_a;
          n_beats++;
          beat++;
          rem--;
          if (beat == int'(exp_bc)) begin
            exp_addr = exp_addr + 29'(exp_bc);
            exp_bc   = (rem < 4) ? 8'(rem) : 8'd4;
            beat     = 0;
          end
        end
      end
      tick();
      start_a = 1'b0;
      cyc++;
    end
    waitrequest_a = 1'b0;
    last_cycles   = cyc;
    check("done_seen", done_a, 1'b1);
    check("done_busy_low", busy_a, 1'b0);
    check("done_write_low", write_a, 1'b0);
  endtask

  initial begin
    reset_n       = 1'b0;
    start_a       = 1'b0;
    sel_a         = 1'b0;
    value_a       = '0;
    waitrequest_a = 1'b0;
    start_b       = 1'b0;
    sel_b         = 1'b0;
    value_b       = '0;
    waitrequest_b = 1'b0;
    clear_mem();

    // Reset state.
    repeat (2) tick();
    check("rst_write", write_a, 1'b0);
    check("rst_busy", busy_a, 1'b0);
    check("rst_done", done_a, 1'b0);
    check("rst_address", address_a, 29'h0);
    check("rst_burstcount", burstcount_a, 8'h0);
    check("rst_dbg", dbg_a, 32'h0);
    check("rst_writedata", writedata_a, 64'h0);
    check("rst_byteenable", byteenable_a, 8'hFF);
    check("rst_write_b", write_b, 1'b0);
    reset_n = 1'b1;
    repeat (2) tick();

    // Buffer 0, no stalls: two bursts of 4, done at N+9.
    start_a_fill(1'b0, 32'hDEADBEEF);
    run_a(1'b0, 32'hDEADBEEF, 1'b0, 0);
    check("t1_cycles", 64'(last_cycles), 64'd9);
    check("t1_beats", 64'(n_beats), 64'd8);
    check("t1_bursts", 64'(n_bursts), 64'd2);
    check("t1_addr0", burst_addr[0], 29'h20);
    check("t1_bc0", burst_bc[0], 8'd4);
    check("t1_addr1", burst_addr[1], 29'h24);
    check("t1_bc1", burst_bc[1], 8'd4);
    check("t1_dbg", dbg_a, 32'd8);
    check_region(32, 32'hDEADBEEF);
    tick();
    check("t1_done_one_cycle", done_a, 1'b0);

    // Short final burst on instance b: bursts of 4 then 2.
    begin
      int          cyc = 1;
      int          nb  = 0;
      int          bi  = 0;
      logic [28:0] a_seen [0:1];
      logic [7:0]  c_seen [0:1];
      start_b = 1'b1;
      value_b = 32'h0BAD_F00D;
      tick();
      start_b = 1'b0;
      while (!done_b && cyc < 100) begin
        if (write_b) begin
          check("b_writedata", writedata_b, 64'h0BADF00D_0BADF00D);
          if (bi == 0 && nb < 2) begin
            a_seen[nb] = address_b;
            c_seen[nb] = burstcount_b;
            nb++;
          end
          bi = (bi + 1 == int'(burstcount_b)) ? 0 : bi + 1;
        end
        tick();
        cyc++;
      end
      check("b_done_seen", done_b, 1'b1);
      check("b_cycles", 64'(cyc), 64'd7);
      check("b_bursts", 64'(nb), 64'd2);
      check("b_addr0", a_seen[0], 29'h20);
      check("b_bc0", c_seen[0], 8'd4);
      check("b_addr1", a_seen[1], 29'h24);
      check("b_bc1", c_seen[1], 8'd2);
      check("b_dbg", dbg_b, 32'd6);
    end
    tick();

    // Random waitrequest: values hold while stalled, exactly 8 beats land.
    clear_mem();
    start_a_fill(1'b0, 32'h1234_5678);
    run_a(1'b0, 32'h1234_5678, 1'b1, 0);
    check("stall_beats", 64'(n_beats), 64'd8);
    check("stall_dbg", dbg_a, 32'd8);
    check_region(32, 32'h1234_5678);
    tick();

    // Buffer 1: first address 29'h28.
    clear_mem();
    start_a_fill(1'b1, 32'hA5A5_5A5A);
    run_a(1'b1, 32'hA5A5_5A5A, 1'b0, 0);
    check("sel1_addr0", burst_addr[0], 29'h28);
    check("sel1_addr1", burst_addr[1], 29'h2C);
    check_region(40, 32'hA5A5_5A5A);
    tick();

    // Start while busy is ignored; start in the done cycle is accepted.
    clear_mem();
    start_a_fill(1'b0, 32'h1111_2222);
    run_a(1'b0, 32'h1111_2222, 1'b0, 3);
    check("busy_start_cycles", 64'(last_cycles), 64'd9);
    check("busy_start_dbg", dbg_a, 32'd8);
    check_region(32, 32'h1111_2222);
    check("restart_done_high", done_a, 1'b1);
    start_a_fill(1'b1, 32'hCAFE_F00D);
    check("restart_address", address_a, 29'h28);
    check("restart_writedata", writedata_a, 64'hCAFEF00D_CAFEF00D);
    run_a(1'b1, 32'hCAFE_F00D, 1'b0, 0);
    check("restart_cycles", 64'(last_cycles), 64'd9);
    tick();

    // Reset mid-fill after 3 beats: write drops at once, no done.
    start_a_fill(1'b0, 32'h7777_8888);
    repeat (3) tick();
    check("pre_reset_dbg", dbg_a, 32'd3);
    #2 reset_n = 1'b0;
    #1;
    check("async_write", write_a, 1'b0);
    check("async_busy", busy_a, 1'b0);
    check("async_done", done_a, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_no_done", done_a, 1'b0);
    end
    reset_n = 1'b1;
    tick();
    check("post_reset_done", done_a, 1'b0);
    check("post_reset_dbg", dbg_a, 32'd0);
    clear_mem();
    start_a_fill(1'b0, 32'h0F0F_F0F0);
    run_a(1'b0, 32'h0F0F_F0F0, 1'b0, 0);
    check("post_reset_cycles", 64'(last_cycles), 64'd9);
    check("post_reset_fill_dbg", dbg_a, 32'd8);
    check_region(32, 32'h0F0F_F0F0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
